// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe match controller: player codes,
// board size, controller states and small move helpers.
package ttt_pkg;

    localparam logic [1:0] P_NONE = 2'b00;
    localparam logic [1:0] P1     = 2'b01;
    localparam logic [1:0] P2     = 2'b10;

    localparam int NUM_CELLS = 9;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        TURN,
        COMMIT,
        EVAL,
        ROUND_END,
        MATCH_END
    } ctrl_state_t;

    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == P1) ? P2 : P1;
    endfunction

    // Positions past the last cell are rejected before the occupancy lookup.
    function automatic logic cell_free(input logic [3:0] pos,
                                       input logic [NUM_CELLS-1:0] occupied);
        if (int'(pos) < NUM_CELLS) begin
            return !occupied[pos];
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn cycle counter: holds zero outside TURN, restarts on a forfeit,
// and flags the last cycle a player is allowed to use.
module turn_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic in_turn,
    input  logic restart,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || !in_turn || restart) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign expired = in_turn && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/match_controller.sv
// Best-of-N tic-tac-toe match sequencer. Define TURN_TIMEOUT_EN to compile in
// the per-turn forfeit timer (turn_timer); otherwise a turn waits forever.
module match_controller
    import ttt_pkg::*;
#(
    parameter int WINS_TO_MATCH  = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 p1_req,
    input  logic [3:0]           p1_pos,
    input  logic                 p2_req,
    input  logic [3:0]           p2_pos,
    input  logic [NUM_CELLS-1:0] occupied,
    input  logic                 win,
    input  logic [1:0]           who,
    input  logic                 no_space,
    output logic                 board_clr,
    output logic                 wr_en,
    output logic [3:0]           wr_pos,
    output logic [1:0]           wr_player,
    output logic [1:0]           turn,
    output logic                 p1_ack,
    output logic                 p1_nack,
    output logic                 p2_ack,
    output logic                 p2_nack,
    output logic [2:0]           p1_score,
    output logic [2:0]           p2_score,
    output logic                 match_over,
    output logic [1:0]           match_winner,
    output logic                 timeout
);

    if (WINS_TO_MATCH < 1 || WINS_TO_MATCH > 7 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("match_controller: WINS_TO_MATCH or TIMEOUT_CYCLES out of range");
    end

    localparam logic [2:0] WIN_TARGET = 3'(WINS_TO_MATCH);

    ctrl_state_t state, state_next;
    logic [1:0]  turn_q, turn_next;
    logic [1:0]  first_q, first_next;
    logic [2:0]  p1_score_q, p1_score_next;
    logic [2:0]  p2_score_q, p2_score_next;
    logic [3:0]  wr_pos_q, wr_pos_next;
    logic [1:0]  wr_player_q, wr_player_next;
    logic        p1_nack_q, p1_nack_next;
    logic        p2_nack_q, p2_nack_next;

    logic        move_req;
    logic [3:0]  move_pos;
    logic        move_legal;
    logic        timer_expired;
    logic        timeout_event;

    // Only the current owner's request is looked at; the other player is ignored.
    assign move_req      = (turn_q == P1) ? p1_req : ((turn_q == P2) ? p2_req : 1'b0);
    assign move_pos      = (turn_q == P1) ? p1_pos : p2_pos;
    assign move_legal    = (state == TURN) && move_req && cell_free(move_pos, occupied);
    assign timeout_event = timer_expired && !move_legal;

`ifdef TURN_TIMEOUT_EN
    logic timeout_q;

    turn_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_turn_timer (
        .clk    (clk),
        .reset  (reset),
        .in_turn(state == TURN),
        .restart(timeout_event),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_event;
        end
    end

    assign timeout = timeout_q;
`else
    assign timer_expired = 1'b0;
    assign timeout       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            turn_q      <= P_NONE;
            first_q     <= P1;
            p1_score_q  <= '0;
            p2_score_q  <= '0;
            wr_pos_q    <= '0;
            wr_player_q <= P_NONE;
            p1_nack_q   <= 1'b0;
            p2_nack_q   <= 1'b0;
        end else begin
            state       <= state_next;
            turn_q      <= turn_next;
            first_q     <= first_next;
            p1_score_q  <= p1_score_next;
            p2_score_q  <= p2_score_next;
            wr_pos_q    <= wr_pos_next;
            wr_player_q <= wr_player_next;
            p1_nack_q   <= p1_nack_next;
            p2_nack_q   <= p2_nack_next;
        end
    end

    always_comb begin
        state_next     = state;
        turn_next      = turn_q;
        first_next     = first_q;
        p1_score_next  = p1_score_q;
        p2_score_next  = p2_score_q;
        wr_pos_next    = wr_pos_q;
        wr_player_next = wr_player_q;
        p1_nack_next   = 1'b0;
        p2_nack_next   = 1'b0;

        unique case (state)
            IDLE, MATCH_END: begin
                if (start) begin
                    state_next    = CLEAR;
                    turn_next     = P_NONE;
                    first_next    = P1;
                    p1_score_next = '0;
                    p2_score_next = '0;
                end
            end
            CLEAR: begin
                state_next = TURN;
                turn_next  = first_q;
            end
            TURN: begin
                if (move_legal) begin
                    state_next     = COMMIT;
                    wr_pos_next    = move_pos;
                    wr_player_next = turn_q;
                end else begin
                    p1_nack_next = move_req && (turn_q == P1);
                    p2_nack_next = move_req && (turn_q == P2);
                    if (timeout_event) begin
                        turn_next = other_player(turn_q);
                    end
                end
            end
            COMMIT: begin
                state_next = EVAL;
            end
            EVAL: begin
                if (win) begin
                    state_next = ROUND_END;
                    turn_next  = P_NONE;
                    if (who == P1) begin
                        p1_score_next = p1_score_q + 3'd1;
                    end else if (who == P2) begin
                        p2_score_next = p2_score_q + 3'd1;
                    end
                end else if (no_space) begin
                    state_next = ROUND_END;
                    turn_next  = P_NONE;
                end else begin
                    state_next = TURN;
                    turn_next  = other_player(turn_q);
                end
            end
            ROUND_END: begin
                if (p1_score_q == WIN_TARGET || p2_score_q == WIN_TARGET) begin
                    state_next = MATCH_END;
                end else begin
                    state_next = CLEAR;
                    first_next = other_player(first_q);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign board_clr    = (state == CLEAR);
    assign wr_en        = (state == COMMIT);
    assign wr_pos       = wr_en ? wr_pos_q : 4'd0;
    assign wr_player    = wr_en ? wr_player_q : P_NONE;
    assign turn         = turn_q;
    assign p1_ack       = wr_en && (wr_player_q == P1);
    assign p2_ack       = wr_en && (wr_player_q == P2);
    assign p1_nack      = p1_nack_q;
    assign p2_nack      = p2_nack_q;
    assign p1_score     = p1_score_q;
    assign p2_score     = p2_score_q;
    assign match_over   = (state == MATCH_END);
    assign match_winner = !match_over ? P_NONE : ((p1_score_q == WIN_TARGET) ? P1 : P2);

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: scripted vector table, hand-written match/reset/timeout
// sequences, and randomized games scored by a board-level model (timeout per TURN_TIMEOUT_EN).
module tb_match_controller;

    localparam int WINS = 2;
    localparam int TMO  = 8;

`ifdef TURN_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       p1_req;
    logic [3:0] p1_pos;
    logic       p2_req;
    logic [3:0] p2_pos;
    logic [8:0] occupied;
    logic       win;
    logic [1:0] who;
    logic       no_space;
    logic       board_clr;
    logic       wr_en;
    logic [3:0] wr_pos;
    logic [1:0] wr_player;
    logic [1:0] turn;
    logic       p1_ack;
    logic       p1_nack;
    logic       p2_ack;
    logic       p2_nack;
    logic [2:0] p1_score;
    logic [2:0] p2_score;
    logic       match_over;
    logic [1:0] match_winner;
    logic       timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic       start;
        logic       p1_req;
        logic [3:0] p1_pos;
        logic       p2_req;
        logic [3:0] p2_pos;
        logic [8:0] occ;
        int         e_clr;
        int         e_wr;
        int         e_pos;
        int         e_player;
        int         e_turn;
        int         e_p1ack;
        int         e_p1nack;
        int         e_p2ack;
        int         e_p2nack;
    } vec_t;

    vec_t vecs [11];
    int   board [9];

    always #5 clk = ~clk;

    match_controller #(
        .WINS_TO_MATCH (WINS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .p1_req      (p1_req),
        .p1_pos      (p1_pos),
        .p2_req      (p2_req),
        .p2_pos      (p2_pos),
        .occupied    (occupied),
        .win         (win),
        .who         (who),
        .no_space    (no_space),
        .board_clr   (board_clr),
        .wr_en       (wr_en),
        .wr_pos      (wr_pos),
        .wr_player   (wr_player),
        .turn        (turn),
        .p1_ack      (p1_ack),
        .p1_nack     (p1_nack),
        .p2_ack      (p2_ack),
        .p2_nack     (p2_nack),
        .p1_score    (p1_score),
        .p2_score    (p2_score),
        .match_over  (match_over),
        .match_winner(match_winner),
        .timeout     (timeout)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic idleInputs();
        start    = 1'b0;
        p1_req   = 1'b0;
        p1_pos   = 4'd0;
        p2_req   = 1'b0;
        p2_pos   = 4'd0;
        win      = 1'b0;
        who      = 2'b00;
        no_space = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        start    = v.start;
        p1_req   = v.p1_req;
        p1_pos   = v.p1_pos;
        p2_req   = v.p2_req;
        p2_pos   = v.p2_pos;
        occupied = v.occ;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " board_clr"}, int'(board_clr), 0);
        checkOutput({tag, " wr_en"}, int'(wr_en), 0);
        checkOutput({tag, " wr_pos"}, int'(wr_pos), 0);
        checkOutput({tag, " wr_player"}, int'(wr_player), 0);
        checkOutput({tag, " turn"}, int'(turn), 0);
        checkOutput({tag, " p1_ack"}, int'(p1_ack), 0);
        checkOutput({tag, " p1_nack"}, int'(p1_nack), 0);
        checkOutput({tag, " p2_ack"}, int'(p2_ack), 0);
        checkOutput({tag, " p2_nack"}, int'(p2_nack), 0);
        checkOutput({tag, " p1_score"}, int'(p1_score), 0);
        checkOutput({tag, " p2_score"}, int'(p2_score), 0);
        checkOutput({tag, " match_over"}, int'(match_over), 0);
        checkOutput({tag, " match_winner"}, int'(match_winner), 0);
        checkOutput({tag, " timeout"}, int'(timeout), 0);
    endtask

    // Legal move by player pl, then EVAL sees the given win/no_space; ends one cycle after EVAL.
    task automatic doMove(input int pl, input int pos, input int w, input int ns, input string tag);
        if (pl == 1) begin
            p1_req = 1'b1;
            p1_pos = 4'(pos);
        end else begin
            p2_req = 1'b1;
            p2_pos = 4'(pos);
        end
        tick();
        checkOutput({tag, " wr_en"}, int'(wr_en), 1);
        checkOutput({tag, " wr_pos"}, int'(wr_pos), pos);
        checkOutput({tag, " wr_player"}, int'(wr_player), pl);
        p1_req   = 1'b0;
        p2_req   = 1'b0;
        win      = (w != 0);
        who      = (w != 0) ? 2'(pl) : 2'b00;
        no_space = (ns != 0);
        tick();
        tick();
        win      = 1'b0;
        who      = 2'b00;
        no_space = 1'b0;
    endtask

    function automatic logic [8:0] occOf();
        logic [8:0] o;
        o = '0;
        for (int i = 0; i < 9; i++) begin
            o[i] = (board[i] != 0);
        end
        return o;
    endfunction

    function automatic bit ownerWins(input int p);
        int l [8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                         '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};
        for (int k = 0; k < 8; k++) begin
            if (board[l[k][0]] == p && board[l[k][1]] == p && board[l[k][2]] == p) begin
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic bit boardFull();
        for (int i = 0; i < 9; i++) begin
            if (board[i] == 0) begin
                return 1'b0;
            end
        end
        return 1'b1;
    endfunction

    initial begin
        int owner, first, score1, score2, turn_cycles;
        int pos, opos, legal, exp_tmo, won, full;
        bit oreq, xreq;
        int free_q[$];

        //            start  p1r   p1pos  p2r   p2pos  occ      clr wr pos pl turn 1a 1n 2a 2n
        vecs[0]  = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 9'h000, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 9'h000, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        vecs[2]  = '{1'b0, 1'b1, 4'd4, 1'b0, 4'd0, 9'h000, 0, 1, 4, 1, 1, 1, 0, 0, 0};
        vecs[3]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 9'h010, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        vecs[4]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 9'h010, 0, 0, 0, 0, 2, 0, 0, 0, 0};
        vecs[5]  = '{1'b0, 1'b1, 4'd0, 1'b1, 4'd4, 9'h010, 0, 0, 0, 0, 2, 0, 0, 0, 1};
        vecs[6]  = '{1'b0, 1'b1, 4'd1, 1'b1, 4'd9, 9'h010, 0, 0, 0, 0, 2, 0, 0, 0, 1};
        vecs[7]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 9'h010, 0, 0, 0, 0, 2, 0, 0, 0, 0};
        vecs[8]  = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd0, 9'h010, 0, 1, 0, 2, 2, 0, 0, 1, 0};
        vecs[9]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 9'h011, 0, 0, 0, 0, 2, 0, 0, 0, 0};
        vecs[10] = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 9'h011, 0, 0, 0, 0, 1, 0, 0, 0, 0};

        reset    = 1'b1;
        occupied = 9'h000;
        idleInputs();
        tick();
        tick();
        checkResetOutputs("reset");
        reset = 1'b0;
        tick();
        checkOutput("idle turn", int'(turn), 0);
        checkOutput("idle board_clr", int'(board_clr), 0);

        // Scripted first round: P1 move, P2 illegal attempts with P1 interfering, P2 move.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            tick();
            checkOutput($sformatf("vec%0d board_clr", i), int'(board_clr), vecs[i].e_clr);
            checkOutput($sformatf("vec%0d wr_en", i), int'(wr_en), vecs[i].e_wr);
            checkOutput($sformatf("vec%0d wr_pos", i), int'(wr_pos), vecs[i].e_pos);
            checkOutput($sformatf("vec%0d wr_player", i), int'(wr_player), vecs[i].e_player);
            checkOutput($sformatf("vec%0d turn", i), int'(turn), vecs[i].e_turn);
            checkOutput($sformatf("vec%0d p1_ack", i), int'(p1_ack), vecs[i].e_p1ack);
            checkOutput($sformatf("vec%0d p1_nack", i), int'(p1_nack), vecs[i].e_p1nack);
            checkOutput($sformatf("vec%0d p2_ack", i), int'(p2_ack), vecs[i].e_p2ack);
            checkOutput($sformatf("vec%0d p2_nack", i), int'(p2_nack), vecs[i].e_p2nack);
        end
        idleInputs();
        occupied = 9'h000;

        // Two P1 round wins take the match; round 2 opens with P2.
        doMove(1, 2, 1, 0, "m1");
        checkOutput("m1 p1_score", int'(p1_score), 1);
        checkOutput("m1 match_over", int'(match_over), 0);
        tick();
        checkOutput("m1 board_clr", int'(board_clr), 1);
        tick();
        checkOutput("round2 first turn", int'(turn), 2);
        doMove(2, 3, 0, 0, "m2");
        checkOutput("m2 turn", int'(turn), 1);
        doMove(1, 5, 1, 0, "m3");
        checkOutput("m3 p1_score", int'(p1_score), 2);
        tick();
        checkOutput("match_over", int'(match_over), 1);
        checkOutput("match_winner", int'(match_winner), 1);
        checkOutput("match p2_score", int'(p2_score), 0);
        tick();
        checkOutput("match_over held", int'(match_over), 1);
        checkOutput("p1_score held", int'(p1_score), 2);

        // Restart from MATCH_END clears scores and P1 moves first.
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restart board_clr", int'(board_clr), 1);
        checkOutput("restart p1_score", int'(p1_score), 0);
        checkOutput("restart match_over", int'(match_over), 0);
        checkOutput("restart match_winner", int'(match_winner), 0);
        tick();
        checkOutput("restart turn", int'(turn), 1);

        // win together with no_space counts as a win; no_space alone is a draw.
        doMove(1, 0, 1, 1, "winspace");
        checkOutput("winspace p1_score", int'(p1_score), 1);
        checkOutput("winspace p2_score", int'(p2_score), 0);
        tick();
        tick();
        checkOutput("winspace next turn", int'(turn), 2);
        doMove(2, 1, 0, 1, "draw");
        checkOutput("draw p1_score", int'(p1_score), 1);
        checkOutput("draw p2_score", int'(p2_score), 0);
        tick();
        checkOutput("draw board_clr", int'(board_clr), 1);
        tick();
        checkOutput("draw next turn", int'(turn), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start ignored turn", int'(turn), 1);
        checkOutput("start ignored clr", int'(board_clr), 0);

        // Reset while the write command is on the bus.
        p1_req = 1'b1;
        p1_pos = 4'd6;
        tick();
        checkOutput("commit wr_en", int'(wr_en), 1);
        p1_req = 1'b0;
        reset  = 1'b1;
        tick();
        checkResetOutputs("reset in commit");
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        checkOutput("post reset turn", int'(turn), 1);

`ifdef TURN_TIMEOUT_EN
        // Idle turn forfeits after TMO cycles; an illegal request does not restart the count.
        for (int k = 1; k < TMO; k++) begin
            if (k == 3) begin
                p1_req = 1'b1;
                p1_pos = 4'd9;
            end
            tick();
            p1_req = 1'b0;
            checkOutput($sformatf("tmo wait%0d timeout", k), int'(timeout), 0);
            checkOutput($sformatf("tmo wait%0d turn", k), int'(turn), 1);
            if (k == 3) begin
                checkOutput("tmo illegal nack", int'(p1_nack), 1);
            end
        end
        tick();
        checkOutput("tmo pulse", int'(timeout), 1);
        checkOutput("tmo turn toggled", int'(turn), 2);
        checkOutput("tmo no write", int'(wr_en), 0);
        tick();
        checkOutput("tmo pulse ends", int'(timeout), 0);
        for (int k = 2; k < TMO; k++) begin
            tick();
            checkOutput($sformatf("tmo2 wait%0d timeout", k), int'(timeout), 0);
        end
        p2_req = 1'b1;
        p2_pos = 4'd7;
        tick();
        p2_req = 1'b0;
        checkOutput("tmo last-cycle wr_en", int'(wr_en), 1);
        checkOutput("tmo last-cycle p2_ack", int'(p2_ack), 1);
        checkOutput("tmo last-cycle timeout", int'(timeout), 0);
        tick();
        checkOutput("tmo after commit", int'(timeout), 0);
        tick();
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            checkOutput($sformatf("no-tmo wait%0d timeout", k), int'(timeout), 0);
            checkOutput($sformatf("no-tmo wait%0d turn", k), int'(turn), 1);
        end
`endif

        // Randomized games against a board model with real tic-tac-toe rules.
        reset = 1'b1;
        idleInputs();
        occupied = 9'h000;
        tick();
        reset = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 9; i++) begin
            board[i] = 0;
        end
        owner       = 1;
        first       = 1;
        score1      = 0;
        score2      = 0;
        turn_cycles = 0;

        for (int a = 0; a < 400; a++) begin
            checkOutput($sformatf("rnd%0d turn", a), int'(turn), owner);
            oreq = ($urandom_range(0, 9) < 8);
            xreq = ($urandom_range(0, 9) < 3);
            free_q = {};
            for (int i = 0; i < 9; i++) begin
                if (board[i] == 0) begin
                    free_q.push_back(i);
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                pos = free_q[$urandom_range(0, free_q.size() - 1)];
            end else begin
                pos = $urandom_range(0, 10);
            end
            opos     = $urandom_range(0, 10);
            occupied = occOf();
            if (owner == 1) begin
                p1_req = oreq;
                p1_pos = 4'(pos);
                p2_req = xreq;
                p2_pos = 4'(opos);
            end else begin
                p2_req = oreq;
                p2_pos = 4'(pos);
                p1_req = xreq;
                p1_pos = 4'(opos);
            end
            legal = 0;
            if (oreq && pos <= 8) begin
                legal = (board[pos] == 0) ? 1 : 0;
            end
            tick();
            p1_req  = 1'b0;
            p2_req  = 1'b0;
            exp_tmo = 0;
            if (legal == 0) begin
                turn_cycles++;
                if (TMO_EN && turn_cycles == TMO) begin
                    exp_tmo = 1;
                end
            end
            checkOutput($sformatf("rnd%0d p1_ack", a), int'(p1_ack), (owner == 1 && legal != 0) ? 1 : 0);
            checkOutput($sformatf("rnd%0d p2_ack", a), int'(p2_ack), (owner == 2 && legal != 0) ? 1 : 0);
            checkOutput($sformatf("rnd%0d p1_nack", a), int'(p1_nack), (owner == 1 && oreq && legal == 0) ? 1 : 0);
            checkOutput($sformatf("rnd%0d p2_nack", a), int'(p2_nack), (owner == 2 && oreq && legal == 0) ? 1 : 0);
            checkOutput($sformatf("rnd%0d wr_en", a), int'(wr_en), legal);
            checkOutput($sformatf("rnd%0d timeout", a), int'(timeout), exp_tmo);
            if (exp_tmo != 0) begin
                owner       = 3 - owner;
                turn_cycles = 0;
            end
            if (legal != 0) begin
                checkOutput($sformatf("rnd%0d wr_pos", a), int'(wr_pos), pos);
                checkOutput($sformatf("rnd%0d wr_player", a), int'(wr_player), owner);
                turn_cycles = 0;
                board[pos]  = owner;
                occupied    = occOf();
                won         = ownerWins(owner) ? 1 : 0;
                full        = boardFull() ? 1 : 0;
                win         = (won != 0);
                who         = (won != 0) ? 2'(owner) : 2'b00;
                no_space    = (full != 0);
                tick();
                tick();
                win      = 1'b0;
                who      = 2'b00;
                no_space = 1'b0;
                if (won != 0 || full != 0) begin
                    if (won != 0) begin
                        if (owner == 1) begin
                            score1++;
                        end else begin
                            score2++;
                        end
                    end
                    checkOutput($sformatf("rnd%0d p1_score", a), int'(p1_score), score1);
                    checkOutput($sformatf("rnd%0d p2_score", a), int'(p2_score), score2);
                    if (score1 == WINS || score2 == WINS) begin
                        tick();
                        checkOutput($sformatf("rnd%0d match_over", a), int'(match_over), 1);
                        checkOutput($sformatf("rnd%0d match_winner", a), int'(match_winner), owner);
                        start = 1'b1;
                        tick();
                        start  = 1'b0;
                        score1 = 0;
                        score2 = 0;
                        first  = 1;
                        checkOutput($sformatf("rnd%0d new match p1_score", a), int'(p1_score), 0);
                    end else begin
                        tick();
                        first = 3 - first;
                    end
                    checkOutput($sformatf("rnd%0d board_clr", a), int'(board_clr), 1);
                    for (int i = 0; i < 9; i++) begin
                        board[i] = 0;
                    end
                    tick();
                    owner = first;
                end else begin
                    owner = 3 - owner;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
